// File: rtl/rf_wport_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_wport_arbiter_pkg;

   localparam int RF_ADDR_W            = 5;
   localparam int RF_DATA_W            = 32;
   localparam int DEFAULT_DEPTH        = 4;
   localparam int DEFAULT_STARVE_LIMIT = 3;

   // One register-file write request as presented to the RF write port.
   typedef struct packed {
      logic                 we;
      logic [RF_ADDR_W-1:0] waddr;
      logic [RF_DATA_W-1:0] wdata;
   } rf_wreq_t;

   // Hazard match: register 0 is never a hazard.
   function automatic logic addr_match(input logic [RF_ADDR_W-1:0] a,
                                       input logic [RF_ADDR_W-1:0] b);
      return (a == b) && (a != '0);
   endfunction

endpackage

// File: rtl/lr_wb_fifo.sv
// In-order FIFO buffering long-latency results until the RF write port is free.
// Destination addresses are held in flops so every entry can be searched for hazards.
module lr_wb_fifo
   import rf_wport_arbiter_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic                              push_i,
   input  logic [RF_ADDR_W-1:0]              push_waddr_i,
   input  logic [RF_DATA_W-1:0]              push_wdata_i,
   input  logic                              pop_i,
   output logic [RF_ADDR_W-1:0]              head_waddr_o,
   output logic [RF_DATA_W-1:0]              head_wdata_o,
   output logic                              full_o,
   output logic                              empty_o,
   output logic [$clog2(DEPTH):0]            count_o,
   output logic [DEPTH-1:0]                  ent_valid_o,
   output logic [DEPTH-1:0][RF_ADDR_W-1:0]   ent_waddr_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]                count_q, count_d;
   logic [DEPTH-1:0]                valid_q;
   logic [DEPTH-1:0][RF_ADDR_W-1:0] waddr_q;
   logic [RF_DATA_W-1:0]            data_q [DEPTH];
   logic                            do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   // A full FIFO refuses a push even when it pops in the same cycle.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   assign head_waddr_o = waddr_q[rd_ptr_q];
   assign head_wdata_o = data_q[rd_ptr_q];
   assign count_o      = count_q;
   assign ent_valid_o  = valid_q;
   assign ent_waddr_o  = waddr_q;

   // Next-state pointers and occupancy; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
   end

   // Control state and searchable addresses; reset discards every entry.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
         waddr_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         // Push and pop never target the same slot: push needs !full, pop needs !empty.
         if (do_push) begin
            valid_q[wr_ptr_q] <= 1'b1;
            waddr_q[wr_ptr_q] <= push_waddr_i;
         end
         if (do_pop) begin
            valid_q[rd_ptr_q] <= 1'b0;
         end
      end
   end

   // Payload storage needs no reset; validity is tracked separately.
   always_ff @(posedge clk) begin
      if (do_push) begin
         data_q[wr_ptr_q] <= push_wdata_i;
      end
   end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Arbitrates the single RF write port between the WB pipeline stream and the
// buffered long-latency result stream, with anti-starvation and hazard lookup.
module rf_wport_arbiter
   import rf_wport_arbiter_pkg::*;
#(
   parameter int DEPTH        = DEFAULT_DEPTH,
   parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    pipe_valid,
   input  logic                    pipe_we,
   input  logic [RF_ADDR_W-1:0]    pipe_waddr,
   input  logic [RF_DATA_W-1:0]    pipe_wdata,
   output logic                    pipe_ready,
   input  logic                    lr_valid,
   input  logic [RF_ADDR_W-1:0]    lr_waddr,
   input  logic [RF_DATA_W-1:0]    lr_wdata,
   output logic                    lr_ready,
   output logic                    rf_we,
   output logic [RF_ADDR_W-1:0]    rf_waddr,
   output logic [RF_DATA_W-1:0]    rf_wdata,
   input  logic [RF_ADDR_W-1:0]    q_addr1,
   input  logic [RF_ADDR_W-1:0]    q_addr2,
   output logic                    pend_hit1,
   output logic                    pend_hit2,
   output logic [$clog2(DEPTH):0]  lr_count
);

   localparam int SC_W = $clog2(STARVE_LIMIT + 1);

   logic                            fifo_push, fifo_full, fifo_empty;
   logic [RF_ADDR_W-1:0]            head_waddr;
   logic [RF_DATA_W-1:0]            head_wdata;
   logic [DEPTH-1:0]                ent_valid;
   logic [DEPTH-1:0][RF_ADDR_W-1:0] ent_waddr;
   logic                            pipe_req, force_lr, grant_pipe, grant_lr;
   logic [SC_W-1:0]                 starve_q, starve_d;
   rf_wreq_t                        wr_q, wr_d;
   logic [DEPTH-1:0]                hit1_vec, hit2_vec;

   // Writes to r0 are acknowledged to the producer but never buffered.
   assign lr_ready  = !fifo_full;
   assign fifo_push = lr_valid && !fifo_full && (lr_waddr != '0);

   lr_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .resetn       (resetn),
      .push_i       (fifo_push),
      .push_waddr_i (lr_waddr),
      .push_wdata_i (lr_wdata),
      .pop_i        (grant_lr),
      .head_waddr_o (head_waddr),
      .head_wdata_o (head_wdata),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty),
      .count_o      (lr_count),
      .ent_valid_o  (ent_valid),
      .ent_waddr_o  (ent_waddr)
   );

   // Pipeline wins unless the buffered head has waited STARVE_LIMIT cycles.
   assign pipe_req   = pipe_valid && pipe_we && (pipe_waddr != '0);
   assign force_lr   = !fifo_empty && (starve_q == SC_W'(STARVE_LIMIT));
   assign pipe_ready = !force_lr;
   assign grant_pipe = !force_lr && pipe_req;
   assign grant_lr   = !fifo_empty && (force_lr || !pipe_req);

   // Aging: count cycles the head is passed over, saturating at the limit.
   always_comb begin
      starve_d = starve_q;
      if (grant_lr || fifo_empty)
         starve_d = '0;
      else if (starve_q != SC_W'(STARVE_LIMIT))
         starve_d = starve_q + SC_W'(1);
   end

   // Output register loads from the winner; address/data hold when idle.
   always_comb begin
      wr_d    = wr_q;
      wr_d.we = 1'b0;
      if (grant_pipe)
         wr_d = '{we: 1'b1, waddr: pipe_waddr, wdata: pipe_wdata};
      else if (grant_lr)
         wr_d = '{we: 1'b1, waddr: head_waddr, wdata: head_wdata};
   end

   // Starvation counter and RF write register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_q <= '0;
         wr_q     <= '0;
      end else begin
         starve_q <= starve_d;
         wr_q     <= wr_d;
      end
   end

   assign rf_we    = wr_q.we;
   assign rf_waddr = wr_q.waddr;
   assign rf_wdata = wr_q.wdata;

   // Hazard CAM over buffered entries; same-cycle pushes are not yet visible.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cam
         assign hit1_vec[gi] = ent_valid[gi] && addr_match(ent_waddr[gi], q_addr1);
         assign hit2_vec[gi] = ent_valid[gi] && addr_match(ent_waddr[gi], q_addr2);
      end
   endgenerate

   assign pend_hit1 = (|hit1_vec) || (wr_q.we && addr_match(wr_q.waddr, q_addr1));
   assign pend_hit2 = (|hit2_vec) || (wr_q.we && addr_match(wr_q.waddr, q_addr2));

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Scenario bench for rf_wport_arbiter with a per-source write scoreboard.
module tb_rf_wport_arbiter;
   import rf_wport_arbiter_pkg::*;

   localparam int DEPTH        = 4;
   localparam int STARVE_LIMIT = 3;

   logic                 clk = 1'b0;
   logic                 resetn;
   logic                 pipe_valid, pipe_we, pipe_ready;
   logic [RF_ADDR_W-1:0] pipe_waddr;
   logic [RF_DATA_W-1:0] pipe_wdata;
   logic                 lr_valid, lr_ready;
   logic [RF_ADDR_W-1:0] lr_waddr;
   logic [RF_DATA_W-1:0] lr_wdata;
   logic                 rf_we;
   logic [RF_ADDR_W-1:0] rf_waddr;
   logic [RF_DATA_W-1:0] rf_wdata;
   logic [RF_ADDR_W-1:0] q_addr1, q_addr2;
   logic                 pend_hit1, pend_hit2;
   logic [$clog2(DEPTH):0] lr_count;

   int n_cmp = 0;
   int n_err = 0;

   // Scoreboard: pipe writes carry the test's pipe address, lr writes are {addr,data}.
   logic [RF_DATA_W-1:0]           pipe_exp [$];
   logic [RF_ADDR_W+RF_DATA_W-1:0] lr_exp   [$];
   logic [RF_ADDR_W-1:0]           paddr;

   always #5 clk = ~clk;

   rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .pipe_valid (pipe_valid),
      .pipe_we    (pipe_we),
      .pipe_waddr (pipe_waddr),
      .pipe_wdata (pipe_wdata),
      .pipe_ready (pipe_ready),
      .lr_valid   (lr_valid),
      .lr_waddr   (lr_waddr),
      .lr_wdata   (lr_wdata),
      .lr_ready   (lr_ready),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .q_addr1    (q_addr1),
      .q_addr2    (q_addr2),
      .pend_hit1  (pend_hit1),
      .pend_hit2  (pend_hit2),
      .lr_count   (lr_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pipe_valid = 1'b0;
      pipe_we    = 1'b0;
      pipe_waddr = '0;
      pipe_wdata = '0;
      lr_valid   = 1'b0;
      lr_waddr   = '0;
      lr_wdata   = '0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      idle_inputs();
      q_addr1 = 5'd3;
      q_addr2 = 5'd4;
      #12;
      n_cmp++;
      if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
         n_err++;
         $display("FAIL reset_rf: we=%b addr=%0d data=%h, required 0/0/0", rf_we, rf_waddr, rf_wdata);
      end
      n_cmp++;
      if (lr_count !== 3'd0) begin
         n_err++;
         $display("FAIL reset_count: got %0d, required 0", lr_count);
      end
      n_cmp++;
      if (pend_hit1 !== 1'b0 || pend_hit2 !== 1'b0) begin
         n_err++;
         $display("FAIL reset_pend: got %b%b, required 00", pend_hit1, pend_hit2);
      end
      @(negedge clk);
      resetn = 1'b1;
      #1;
      n_cmp++;
      if (lr_ready !== 1'b1 || pipe_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: lr_ready=%b pipe_ready=%b, required 1/1", lr_ready, pipe_ready);
      end
      tick();
      $display("test_reset done");
   endtask

   task automatic test_pipe_only();
      logic [RF_DATA_W-1:0] exp_d;
      paddr = 5'd5;
      for (int c = 0; c < 3; c++) begin
         pipe_valid = 1'b1;
         pipe_we    = 1'b1;
         pipe_waddr = 5'd5;
         pipe_wdata = 32'h1234;
         #1;
         n_cmp++;
         if (pipe_ready !== 1'b1) begin
            n_err++;
            $display("FAIL pipe_only_ready c%0d: got %b, required 1", c, pipe_ready);
         end
         pipe_exp.push_back(32'h1234);
         tick();
         exp_d = pipe_exp.pop_front();
         n_cmp++;
         if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== exp_d) begin
            n_err++;
            $display("FAIL pipe_only_write c%0d: we=%b addr=%0d data=%h, required 1/5/%h", c, rf_we, rf_waddr, rf_wdata, exp_d);
         end
      end
      idle_inputs();
      tick();
      n_cmp++;
      if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
         n_err++;
         $display("FAIL pipe_only_hold: we=%b addr=%0d data=%h, required 0/5/1234", rf_we, rf_waddr, rf_wdata);
      end
      $display("test_pipe_only done");
   endtask

   task automatic test_idle_drain();
      q_addr1    = 5'd7;
      q_addr2    = 5'd0;
      pipe_valid = 1'b1;
      pipe_we    = 1'b0;
      pipe_waddr = 5'd7;
      lr_valid   = 1'b1;
      lr_waddr   = 5'd7;
      lr_wdata   = 32'hAAAA;
      #1;
      n_cmp++;
      if (lr_ready !== 1'b1 || pend_hit1 !== 1'b0) begin
         n_err++;
         $display("FAIL drain_push: lr_ready=%b pend_hit1=%b, required 1/0", lr_ready, pend_hit1);
      end
      tick();
      lr_valid = 1'b0;
      #1;
      n_cmp++;
      if (lr_count !== 3'd1 || rf_we !== 1'b0 || pend_hit1 !== 1'b1) begin
         n_err++;
         $display("FAIL drain_buffered: count=%0d rf_we=%b pend=%b, required 1/0/1", lr_count, rf_we, pend_hit1);
      end
      tick();
      n_cmp++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hAAAA || lr_count !== 3'd0) begin
         n_err++;
         $display("FAIL drain_write: we=%b addr=%0d data=%h count=%0d, required 1/7/aaaa/0", rf_we, rf_waddr, rf_wdata, lr_count);
      end
      n_cmp++;
      if (pend_hit1 !== 1'b1) begin
         n_err++;
         $display("FAIL drain_pend_inflight: got %b, required 1", pend_hit1);
      end
      idle_inputs();
      tick();
      n_cmp++;
      if (rf_we !== 1'b0 || pend_hit1 !== 1'b0) begin
         n_err++;
         $display("FAIL drain_after: rf_we=%b pend=%b, required 0/0", rf_we, pend_hit1);
      end
      $display("test_idle_drain done");
   endtask

   task automatic test_starvation();
      logic [RF_DATA_W-1:0]           exp_d;
      logic [RF_ADDR_W+RF_DATA_W-1:0] exp_l;
      logic                           exp_ready;
      int                             acc = 0;
      paddr = 5'd5;
      for (int c = 0; c < 7; c++) begin
         pipe_valid = 1'b1;
         pipe_we    = 1'b1;
         pipe_waddr = 5'd5;
         pipe_wdata = 32'h5000 + 32'(acc);
         lr_valid   = (c == 0);
         lr_waddr   = 5'd9;
         lr_wdata   = 32'h9999_0009;
         #1;
         exp_ready = (c != 4);
         n_cmp++;
         if (pipe_ready !== exp_ready) begin
            n_err++;
            $display("FAIL starve_ready c%0d: got %b, required %b", c, pipe_ready, exp_ready);
         end
         if (c == 0) lr_exp.push_back({5'd9, 32'h9999_0009});
         if (exp_ready) begin
            pipe_exp.push_back(pipe_wdata);
            acc++;
         end
         tick();
         if (rf_we === 1'b1) begin
            n_cmp++;
            if (rf_waddr == paddr) begin
               exp_d = (pipe_exp.size() != 0) ? pipe_exp.pop_front() : 32'hx;
               if (rf_wdata !== exp_d) begin
                  n_err++;
                  $display("FAIL starve_pipe_write c%0d: data=%h, required %h", c, rf_wdata, exp_d);
               end
            end else begin
               exp_l = (lr_exp.size() != 0) ? lr_exp.pop_front() : 'x;
               if ({rf_waddr, rf_wdata} !== exp_l) begin
                  n_err++;
                  $display("FAIL starve_lr_write c%0d: addr=%0d data=%h, required %h", c, rf_waddr, rf_wdata, exp_l);
               end
            end
         end
         if (c == 4) begin
            n_cmp++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'd9) begin
               n_err++;
               $display("FAIL starve_forced_slot: we=%b addr=%0d, required 1/9", rf_we, rf_waddr);
            end
         end
      end
      idle_inputs();
      tick();
      n_cmp++;
      if (pipe_exp.size() != 0 || lr_exp.size() != 0 || lr_count !== 3'd0) begin
         n_err++;
         $display("FAIL starve_leftover: pipe=%0d lr=%0d count=%0d, required 0/0/0", pipe_exp.size(), lr_exp.size(), lr_count);
      end
      $display("test_starvation done");
   endtask

   task automatic test_full();
      logic [RF_DATA_W-1:0]           exp_d;
      logic [RF_ADDR_W+RF_DATA_W-1:0] exp_l;
      logic [RF_ADDR_W-1:0]           lr_addrs [5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6};
      int                             li  = 0;
      int                             acc = 0;
      paddr = 5'd20;
      for (int c = 0; c < 24; c++) begin
         pipe_valid = 1'b1;
         pipe_we    = 1'b1;
         pipe_waddr = 5'd20;
         pipe_wdata = 32'h2000 + 32'(acc);
         lr_valid   = (li < 5);
         lr_waddr   = (li < 5) ? lr_addrs[li] : 5'd0;
         lr_wdata   = 32'h4000_0000 + 32'(li);
         #1;
         if (c == 4) begin
            n_cmp++;
            if (lr_ready !== 1'b0 || lr_count !== 3'd4 || pipe_ready !== 1'b0) begin
               n_err++;
               $display("FAIL full_c4: lr_ready=%b count=%0d pipe_ready=%b, required 0/4/0", lr_ready, lr_count, pipe_ready);
            end
         end
         if (c == 5) begin
            n_cmp++;
            if (lr_ready !== 1'b1 || lr_count !== 3'd3) begin
               n_err++;
               $display("FAIL full_c5: lr_ready=%b count=%0d, required 1/3", lr_ready, lr_count);
            end
         end
         if (lr_valid && lr_ready) begin
            lr_exp.push_back({lr_waddr, lr_wdata});
            li++;
         end
         if (pipe_ready) begin
            pipe_exp.push_back(pipe_wdata);
            acc++;
         end
         tick();
         if (rf_we === 1'b1) begin
            n_cmp++;
            if (rf_waddr == paddr) begin
               exp_d = (pipe_exp.size() != 0) ? pipe_exp.pop_front() : 32'hx;
               if (rf_wdata !== exp_d) begin
                  n_err++;
                  $display("FAIL full_pipe_write c%0d: data=%h, required %h", c, rf_wdata, exp_d);
               end
            end else begin
               exp_l = (lr_exp.size() != 0) ? lr_exp.pop_front() : 'x;
               if ({rf_waddr, rf_wdata} !== exp_l) begin
                  n_err++;
                  $display("FAIL full_lr_write c%0d: addr=%0d data=%h, required %h", c, rf_waddr, rf_wdata, exp_l);
               end
            end
         end
      end
      idle_inputs();
      tick();
      n_cmp++;
      if (li != 5 || pipe_exp.size() != 0 || lr_exp.size() != 0 || lr_count !== 3'd0) begin
         n_err++;
         $display("FAIL full_leftover: pushed=%0d pipe=%0d lr=%0d count=%0d, required 5/0/0/0", li, pipe_exp.size(), lr_exp.size(), lr_count);
      end
      $display("test_full done");
   endtask

   task automatic test_hazard();
      logic [RF_DATA_W-1:0]           exp_d;
      logic [RF_ADDR_W+RF_DATA_W-1:0] exp_l;
      logic                           exp_hit;
      int                             acc = 0;
      paddr   = 5'd21;
      q_addr1 = 5'd12;
      q_addr2 = 5'd0;
      for (int c = 0; c < 7; c++) begin
         pipe_valid = 1'b1;
         pipe_we    = 1'b1;
         pipe_waddr = 5'd21;
         pipe_wdata = 32'h2100 + 32'(acc);
         lr_valid   = (c == 0);
         lr_waddr   = 5'd12;
         lr_wdata   = 32'hC0C0;
         #1;
         exp_hit = (c >= 1) && (c <= 5);
         n_cmp++;
         if (pend_hit1 !== exp_hit || pend_hit2 !== 1'b0) begin
            n_err++;
            $display("FAIL hazard_pend c%0d: hit1=%b hit2=%b, required %b/0", c, pend_hit1, pend_hit2, exp_hit);
         end
         if (c == 0) lr_exp.push_back({5'd12, 32'hC0C0});
         if (pipe_ready) begin
            pipe_exp.push_back(pipe_wdata);
            acc++;
         end
         tick();
         if (rf_we === 1'b1) begin
            n_cmp++;
            if (rf_waddr == paddr) begin
               exp_d = (pipe_exp.size() != 0) ? pipe_exp.pop_front() : 32'hx;
               if (rf_wdata !== exp_d) begin
                  n_err++;
                  $display("FAIL hazard_pipe_write c%0d: data=%h, required %h", c, rf_wdata, exp_d);
               end
            end else begin
               exp_l = (lr_exp.size() != 0) ? lr_exp.pop_front() : 'x;
               if ({rf_waddr, rf_wdata} !== exp_l) begin
                  n_err++;
                  $display("FAIL hazard_lr_write c%0d: addr=%0d data=%h, required %h", c, rf_waddr, rf_wdata, exp_l);
               end
            end
         end
      end
      idle_inputs();
      tick();
      // A result for r0 is acknowledged but must leave no trace.
      lr_valid = 1'b1;
      lr_waddr = 5'd0;
      lr_wdata = 32'hDEAD;
      #1;
      n_cmp++;
      if (lr_ready !== 1'b1) begin
         n_err++;
         $display("FAIL r0_ready: got %b, required 1", lr_ready);
      end
      tick();
      lr_valid = 1'b0;
      n_cmp++;
      if (lr_count !== 3'd0 || rf_we !== 1'b0) begin
         n_err++;
         $display("FAIL r0_count: count=%0d rf_we=%b, required 0/0", lr_count, rf_we);
      end
      tick();
      n_cmp++;
      if (rf_we !== 1'b0 || pipe_exp.size() != 0 || lr_exp.size() != 0) begin
         n_err++;
         $display("FAIL r0_nowrite: rf_we=%b pipe=%0d lr=%0d, required 0/0/0", rf_we, pipe_exp.size(), lr_exp.size());
      end
      $display("test_hazard done");
   endtask

   task automatic test_reset_mid();
      logic [RF_DATA_W-1:0]           exp_d;
      logic [RF_ADDR_W+RF_DATA_W-1:0] exp_l;
      int                             acc = 0;
      paddr   = 5'd22;
      q_addr1 = 5'd13;
      for (int c = 0; c < 3; c++) begin
         pipe_valid = 1'b1;
         pipe_we    = 1'b1;
         pipe_waddr = 5'd22;
         pipe_wdata = 32'h2200 + 32'(acc);
         lr_valid   = 1'b1;
         lr_waddr   = 5'd13 + 5'(c);
         lr_wdata   = 32'h1300 + 32'(c);
         #1;
         if (lr_ready) lr_exp.push_back({lr_waddr, lr_wdata});
         if (pipe_ready) begin
            pipe_exp.push_back(pipe_wdata);
            acc++;
         end
         tick();
         if (rf_we === 1'b1) begin
            n_cmp++;
            if (rf_waddr == paddr) begin
               exp_d = (pipe_exp.size() != 0) ? pipe_exp.pop_front() : 32'hx;
               if (rf_wdata !== exp_d) begin
                  n_err++;
                  $display("FAIL rstmid_pipe_write c%0d: data=%h, required %h", c, rf_wdata, exp_d);
               end
            end else begin
               exp_l = (lr_exp.size() != 0) ? lr_exp.pop_front() : 'x;
               if ({rf_waddr, rf_wdata} !== exp_l) begin
                  n_err++;
                  $display("FAIL rstmid_lr_write c%0d: addr=%0d data=%h, required %h", c, rf_waddr, rf_wdata, exp_l);
               end
            end
         end
      end
      n_cmp++;
      if (lr_count !== 3'd3 || rf_we !== 1'b1 || pend_hit1 !== 1'b1) begin
         n_err++;
         $display("FAIL rstmid_before: count=%0d rf_we=%b pend=%b, required 3/1/1", lr_count, rf_we, pend_hit1);
      end
      #1;
      resetn = 1'b0;
      idle_inputs();
      #1;
      n_cmp++;
      if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || lr_count !== 3'd0 || pend_hit1 !== 1'b0) begin
         n_err++;
         $display("FAIL rstmid_async: rf_we=%b addr=%0d count=%0d pend=%b, required 0/0/0/0", rf_we, rf_waddr, lr_count, pend_hit1);
      end
      lr_exp.delete();
      tick();
      resetn = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         n_cmp++;
         if (rf_we !== 1'b0 || lr_count !== 3'd0) begin
            n_err++;
            $display("FAIL rstmid_stale c%0d: rf_we=%b addr=%0d count=%0d, required 0/-/0", c, rf_we, rf_waddr, lr_count);
         end
      end
      n_cmp++;
      if (pipe_exp.size() != 0) begin
         n_err++;
         $display("FAIL rstmid_pipe_lost: %0d writes missing, required 0", pipe_exp.size());
      end
      $display("test_reset_mid done");
   endtask

   initial begin
      idle_inputs();
      q_addr1 = '0;
      q_addr2 = '0;
      paddr   = '0;
      resetn  = 1'b0;
      test_reset();
      test_pipe_only();
      test_idle_drain();
      test_starvation();
      test_full();
      test_hazard();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

endmodule
